hilo_muldiv_unit: RTL
=====================

Name: hilo_muldiv_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage of the MIPS pipeline.
- Consumes the 4-bit ALU control code from the ALU control decoder and executes mult (4'h5) and div (4'h8) iteratively into architectural HI/LO registers.
- Serves mfhi (4'h3) and mflo (4'h4) reads.
- Raises busy so hazard logic stalls ID/EX while an operation is in flight.

Parameters:
- XLEN, 32, operand/HI/LO width.
- CNT_W, 6, iteration counter width (must hold XLEN).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- alu_ctrl  in  4  ALU control code from decoder
- ex_valid  in  1  EX-stage instruction valid (not bubble/flushed)
- op_a  in  XLEN  rs value (dividend/multiplicand)
- op_b  in  XLEN  rt value (divisor/multiplier)
- busy  out  1  operation in flight; hazard unit stalls on it
- done  out  1  one-cycle pulse, HI/LO commit this cycle
- div_zero  out  1  one-cycle pulse with done when divisor was 0
- hi  out  XLEN  HI register
- lo  out  XLEN  LO register
- mf_result  out  XLEN  hi when alu_ctrl==4'h3, lo when 4'h4, else 0 (combinational)

Behaviour:
- Reset: interface is one clock domain; reset is synchronous and active-low (rst_n sampled on rising clk). State=IDLE, hi=lo=0, busy=done=div_zero=0, counter=0. Reset mid-operation aborts the operation; HI/LO are cleared, not committed.
- Accept: at the rising edge where state==IDLE, ex_valid=1 and alu_ctrl is 4'h5 or 4'h8, latch sign bits and |op_a|, |op_b| (two's-complement magnitude), record op type, and go to RUN.
- Start while busy: ignored, no queueing. The hazard unit guarantees a stall.
- States:
  - IDLE: busy=0.
  - RUN: XLEN iterations, one per cycle, counter 0..XLEN-1. Mult uses shift-add over a 2*XLEN accumulator. Div is restoring: shift remainder left, subtract, set quotient bit.
  - FIX: one cycle. Apply signs (product: sa^sb; quotient: sa^sb; remainder: sa). Drive done=1. Commit {hi,lo} at the FIX->IDLE edge.
- Timing: busy=1 from the cycle after accept through the FIX cycle inclusive, exactly XLEN+1=33 cycles. New HI/LO are visible the cycle busy falls.
- Result mapping:
  - mult: hi=product[63:32], lo=product[31:0].
  - div: lo=quotient, hi=remainder. Truncating division; the remainder sign follows the dividend.
- Divide by zero: detected at accept. RUN is skipped (IDLE->FIX, busy for 1 cycle). Commit hi=op_a unchanged, lo=32'hFFFFFFFF. div_zero=1 with done.
- Overflow: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (XLEN-bit truncation of the negated magnitude; no trap).
- Width rule: magnitudes are XLEN-bit unsigned; |0x80000000| = 0x80000000 is handled without sign loss.
- mfhi/mflo while busy returns old HI/LO. The stall prevents this from being architecturally visible.
- Other alu_ctrl codes: the unit is idle and has no side effects.

Optional Feature:
- MULDIV_UNSIGNED_EN
  - Defined: additionally accepts multu (4'h9) and divu (4'ha). Sign capture is forced to 0 and the FIX stage passes values unmodified. Divide by zero behaves as above.
  - Undefined: 4'h9 and 4'ha are treated as non-muldiv codes and ignored.

Decomposition:
- Shared package mips_alu_pkg holds:
  - ALU control code localparams (ALU_ADD=4'h2, ALU_SUB=4'h6, ALU_MFHI=4'h3, ALU_MFLO=4'h4, ALU_MULT=4'h5, ALU_DIV=4'h8, ALU_MULTU=4'h9, ALU_DIVU=4'ha), shared with the ALU control decoder.
  - The muldiv state encoding (IDLE/RUN/FIX).
  - XLEN default.
- One sub-module, muldiv_iter_step: a combinational single-iteration datapath (shift-add or restore-subtract step, selected by op type), instantiated once. The FSM, counter, sign fix and HI/LO stay in the top.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles -> hi=lo=0, busy=0, done=0; mf_result=0 under alu_ctrl=4'h3.
- mult 7 * -3 (op_b=0xFFFFFFFD) -> busy for 33 cycles, done pulse once; hi=0xFFFFFFFF, lo=0xFFFFFFEB; then alu_ctrl=4'h4 gives mf_result=0xFFFFFFEB.
- div -7/2 (0xFFFFFFF9, 2) -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1), div_zero=0, 33-cycle latency.
- div 5/0 -> busy for 1 cycle, done and div_zero pulse together; hi=5, lo=0xFFFFFFFF.
- div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0. Also mult 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
- Mid-op events:
  - Second start (alu_ctrl=4'h5, ex_valid=1) at RUN cycle 10 -> ignored; first result commits unchanged.
  - rst_n=0 at RUN cycle 20 -> next cycle busy=0, hi=lo=0, no done pulse.

Source files
------------

// File: rtl/mips_alu_pkg.sv
// mips_alu_pkg: ALU control codes, muldiv state encoding and default datapath width
package mips_alu_pkg;
  localparam int XLEN_DEFAULT = 32;
  localparam logic [3:0] ALU_ADD   = 4'h2;
  localparam logic [3:0] ALU_SUB   = 4'h6;
  localparam logic [3:0] ALU_MFHI  = 4'h3;
  localparam logic [3:0] ALU_MFLO  = 4'h4;
  localparam logic [3:0] ALU_MULT  = 4'h5;
  localparam logic [3:0] ALU_DIV   = 4'h8;
  localparam logic [3:0] ALU_MULTU = 4'h9;
  localparam logic [3:0] ALU_DIVU  = 4'ha;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} muldiv_state_e;
endpackage

// File: rtl/muldiv_iter_step.sv
// muldiv_iter_step: one shift-add (mult) or restoring-subtract (div) iteration over {hi,lo} accumulator
module muldiv_iter_step #(
  parameter int XLEN = 32
) (
  input  logic              is_div_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opd_i,
  output logic [2*XLEN-1:0] acc_o
);
  logic [XLEN:0] sum, rem_sh;
  logic ge;
  always_comb begin
    sum    = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opd_i} : '0);
    rem_sh = acc_i[2*XLEN-1:XLEN-1];
    ge     = rem_sh >= {1'b0, opd_i};
    acc_o  = is_div_i ? {(ge ? XLEN'(rem_sh - {1'b0, opd_i}) : rem_sh[XLEN-1:0]), acc_i[XLEN-2:0], ge}
                      : {sum, acc_i[XLEN-1:1]};
  end
endmodule

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: iterative signed mult/div into HI/LO with mfhi/mflo read port.
// Define MULDIV_UNSIGNED_EN to also accept multu/divu.
module hilo_muldiv_unit
  import mips_alu_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      alu_ctrl,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic            div_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic [XLEN-1:0] mf_result
);
  muldiv_state_e state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2*XLEN-1:0] acc_q, acc_d, prod_d;
  logic [XLEN-1:0] opd_q, a_mag, b_mag, quo_d, rem_d, hi_d, lo_d;
  logic sa_q, sb_q, div_q, dz_q, is_md, is_div, sgn, sa, sb, start, b_zero;
`ifdef MULDIV_UNSIGNED_EN
  assign is_md  = alu_ctrl == ALU_MULT || alu_ctrl == ALU_DIV || alu_ctrl == ALU_MULTU || alu_ctrl == ALU_DIVU;
  assign is_div = alu_ctrl == ALU_DIV || alu_ctrl == ALU_DIVU;
  assign sgn    = alu_ctrl == ALU_MULT || alu_ctrl == ALU_DIV;
`else
  assign is_md  = alu_ctrl == ALU_MULT || alu_ctrl == ALU_DIV;
  assign is_div = alu_ctrl == ALU_DIV;
  assign sgn    = 1'b1;
`endif
  assign start  = state_q == S_IDLE && ex_valid && is_md;
  assign b_zero = op_b == '0;
  assign sa     = sgn & op_a[XLEN-1];
  assign sb     = sgn & op_b[XLEN-1];
  assign a_mag  = sa ? -op_a : op_a;
  assign b_mag  = sb ? -op_b : op_b;
  muldiv_iter_step #(.XLEN(XLEN)) u_step (
    .is_div_i (div_q),
    .acc_i    (acc_q),
    .opd_i    (opd_q),
    .acc_o    (acc_d)
  );
  // divide-by-zero keeps the raw dividend in the low half so HI can return it untouched
  always_comb begin
    prod_d = sa_q ^ sb_q ? -acc_q : acc_q;
    quo_d  = sa_q ^ sb_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_d  = sa_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    hi_d   = dz_q ? acc_q[XLEN-1:0] : div_q ? rem_d : prod_d[2*XLEN-1:XLEN];
    lo_d   = dz_q ? '1 : div_q ? quo_d : prod_d[XLEN-1:0];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opd_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      div_q   <= 1'b0;
      dz_q    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          state_q <= is_div && b_zero ? S_FIX : S_RUN;
          cnt_q   <= '0;
          acc_q   <= {{XLEN{1'b0}}, is_div ? (b_zero ? op_a : a_mag) : b_mag};
          opd_q   <= is_div ? b_mag : a_mag;
          sa_q    <= sa;
          sb_q    <= sb;
          div_q   <= is_div;
          dz_q    <= is_div && b_zero;
        end
        S_RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(XLEN-1)) state_q <= S_FIX;
        end
        S_FIX: begin
          hi      <= hi_d;
          lo      <= lo_d;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign busy      = state_q != S_IDLE;
  assign done      = state_q == S_FIX;
  assign div_zero  = done & dz_q;
  assign mf_result = alu_ctrl == ALU_MFHI ? hi : alu_ctrl == ALU_MFLO ? lo : '0;
endmodule
